// File: rtl/vxe_axi4slv_burst_biu.sv
// AXI4 slave burst front-end that turns AXI read/write bursts into single-beat
// BIU requests; the read and write paths are independent single-outstanding FSMs.
module vxe_axi4slv_burst_biu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    S_AXI4_ACLK,
  input  logic                    S_AXI4_ARESET,
  // AW channel
  input  logic [ID_WIDTH-1:0]     S_AXI4_AWID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI4_AWADDR,
  input  logic [7:0]              S_AXI4_AWLEN,
  input  logic [2:0]              S_AXI4_AWSIZE,
  input  logic [1:0]              S_AXI4_AWBURST,
  input  logic                    S_AXI4_AWLOCK,
  input  logic [2:0]              S_AXI4_AWPROT,
  input  logic                    S_AXI4_AWVALID,
  output logic                    S_AXI4_AWREADY,
  // W channel
  input  logic [DATA_WIDTH-1:0]   S_AXI4_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI4_WSTRB,
  input  logic                    S_AXI4_WLAST,
  input  logic                    S_AXI4_WVALID,
  output logic                    S_AXI4_WREADY,
  // B channel
  output logic [ID_WIDTH-1:0]     S_AXI4_BID,
  output logic [1:0]              S_AXI4_BRESP,
  output logic                    S_AXI4_BVALID,
  input  logic                    S_AXI4_BREADY,
  // AR channel
  input  logic [ID_WIDTH-1:0]     S_AXI4_ARID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI4_ARADDR,
  input  logic [7:0]              S_AXI4_ARLEN,
  input  logic [2:0]              S_AXI4_ARSIZE,
  input  logic [1:0]              S_AXI4_ARBURST,
  input  logic                    S_AXI4_ARLOCK,
  input  logic [2:0]              S_AXI4_ARPROT,
  input  logic                    S_AXI4_ARVALID,
  output logic                    S_AXI4_ARREADY,
  // R channel
  output logic [ID_WIDTH-1:0]     S_AXI4_RID,
  output logic [DATA_WIDTH-1:0]   S_AXI4_RDATA,
  output logic [1:0]              S_AXI4_RRESP,
  output logic                    S_AXI4_RLAST,
  output logic                    S_AXI4_RVALID,
  input  logic                    S_AXI4_RREADY,
  // BIU write port
  output logic [ADDR_WIDTH-1:0]   biu_waddr,
  output logic                    biu_wenable,
  output logic [DATA_WIDTH-1:0]   biu_wdata,
  output logic [DATA_WIDTH/8-1:0] biu_wben,
  input  logic                    biu_waccept,
  input  logic                    biu_werror,
  // BIU read port
  output logic [ADDR_WIDTH-1:0]   biu_raddr,
  output logic                    biu_renable,
  input  logic [DATA_WIDTH-1:0]   biu_rdata,
  input  logic                    biu_raccept,
  input  logic                    biu_rerror
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned MAX_SIZE   = $clog2(STRB_WIDTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_BIU, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_BIU, R_DATA} rstate_t;

  // Lock and protection attributes carry no meaning for this slave.
  logic unused_attr;
  assign unused_attr = ^{S_AXI4_AWLOCK, S_AXI4_AWPROT, S_AXI4_ARLOCK, S_AXI4_ARPROT};

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [2:0]            eff;
    logic [ADDR_WIDTH-1:0] nbytes, incr, wmask, res;
    eff    = (size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : size;
    nbytes = ADDR_WIDTH'(1) << eff;
    incr   = (addr & ~(nbytes - ADDR_WIDTH'(1))) + nbytes;
    // Wrap window is (LEN+1)*bytes; a zero mask means WRAP degrades to INCR.
    case (len)
      8'd1:    wmask = (nbytes << 1) - ADDR_WIDTH'(1);
      8'd3:    wmask = (nbytes << 2) - ADDR_WIDTH'(1);
      8'd7:    wmask = (nbytes << 3) - ADDR_WIDTH'(1);
      8'd15:   wmask = (nbytes << 4) - ADDR_WIDTH'(1);
      default: wmask = '0;
    endcase
    case (burst)
      2'b00:   res = addr;
      2'b10:   res = (wmask != '0) ? ((addr & ~wmask) | (incr & wmask)) : incr;
      default: res = incr;
    endcase
    return res;
  endfunction

  // ---------------- write path ----------------
  wstate_t                w_state, w_next;
  logic [ID_WIDTH-1:0]    w_id;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [7:0]             w_len, w_cnt;
  logic [2:0]             w_size;
  logic [1:0]             w_burst;
  logic                   w_err;
  logic [DATA_WIDTH-1:0]  w_data;
  logic [STRB_WIDTH-1:0]  w_strb;

  always_ff @(posedge S_AXI4_ACLK) begin
    if (S_AXI4_ARESET) w_state <= W_IDLE;
    else               w_state <= w_next;
  end

  always_ff @(posedge S_AXI4_ACLK) begin
    if (S_AXI4_ARESET) begin
      w_id <= '0; w_addr <= '0; w_len <= '0; w_cnt <= '0; w_size <= '0;
      w_burst <= '0; w_err <= 1'b0; w_data <= '0; w_strb <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (S_AXI4_AWVALID) begin
          w_id    <= S_AXI4_AWID;
          w_addr  <= S_AXI4_AWADDR;
          w_len   <= S_AXI4_AWLEN;
          w_size  <= S_AXI4_AWSIZE;
          w_burst <= S_AXI4_AWBURST;
          w_cnt   <= '0;
          w_err   <= 1'b0;
        end
        W_DATA: if (S_AXI4_WVALID) begin
          w_data <= S_AXI4_WDATA;
          w_strb <= S_AXI4_WSTRB;
          if (S_AXI4_WLAST != (w_cnt == w_len)) w_err <= 1'b1;
        end
        W_BIU: if (biu_waccept) begin
          if (biu_werror) w_err <= 1'b1;
          if (w_cnt != w_len) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next         = w_state;
    S_AXI4_AWREADY = 1'b0;
    S_AXI4_WREADY  = 1'b0;
    S_AXI4_BVALID  = 1'b0;
    biu_wenable    = 1'b0;
    S_AXI4_BID     = '0;
    S_AXI4_BRESP   = '0;
    biu_waddr      = '0;
    biu_wdata      = '0;
    biu_wben       = '0;
    if (!S_AXI4_ARESET) begin
      S_AXI4_BID   = w_id;
      S_AXI4_BRESP = w_err ? 2'b10 : 2'b00;
      biu_waddr    = w_addr;
      biu_wdata    = w_data;
      biu_wben     = w_strb;
      case (w_state)
        W_IDLE: begin
          S_AXI4_AWREADY = 1'b1;
          if (S_AXI4_AWVALID) w_next = W_DATA;
        end
        W_DATA: begin
          S_AXI4_WREADY = 1'b1;
          if (S_AXI4_WVALID) w_next = W_BIU;
        end
        W_BIU: begin
          biu_wenable = 1'b1;
          if (biu_waccept) w_next = (w_cnt == w_len) ? W_RESP : W_DATA;
        end
        W_RESP: begin
          S_AXI4_BVALID = 1'b1;
          if (S_AXI4_BREADY) w_next = W_IDLE;
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  rstate_t                r_state, r_next;
  logic [ID_WIDTH-1:0]    r_id;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [7:0]             r_len, r_cnt;
  logic [2:0]             r_size;
  logic [1:0]             r_burst;
  logic                   r_err;
  logic [DATA_WIDTH-1:0]  r_data;

  always_ff @(posedge S_AXI4_ACLK) begin
    if (S_AXI4_ARESET) r_state <= R_IDLE;
    else               r_state <= r_next;
  end

  always_ff @(posedge S_AXI4_ACLK) begin
    if (S_AXI4_ARESET) begin
      r_id <= '0; r_addr <= '0; r_len <= '0; r_cnt <= '0; r_size <= '0;
      r_burst <= '0; r_err <= 1'b0; r_data <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (S_AXI4_ARVALID) begin
          r_id    <= S_AXI4_ARID;
          r_addr  <= S_AXI4_ARADDR;
          r_len   <= S_AXI4_ARLEN;
          r_size  <= S_AXI4_ARSIZE;
          r_burst <= S_AXI4_ARBURST;
          r_cnt   <= '0;
        end
        R_BIU: if (biu_raccept) begin
          r_data <= biu_rdata;
          r_err  <= biu_rerror;
        end
        R_DATA: if (S_AXI4_RREADY && (r_cnt != r_len)) begin
          r_cnt  <= r_cnt + 8'd1;
          r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    r_next         = r_state;
    S_AXI4_ARREADY = 1'b0;
    S_AXI4_RVALID  = 1'b0;
    S_AXI4_RLAST   = 1'b0;
    biu_renable    = 1'b0;
    S_AXI4_RID     = '0;
    S_AXI4_RDATA   = '0;
    S_AXI4_RRESP   = '0;
    biu_raddr      = '0;
    if (!S_AXI4_ARESET) begin
      S_AXI4_RID   = r_id;
      S_AXI4_RDATA = r_data;
      S_AXI4_RRESP = r_err ? 2'b10 : 2'b00;
      biu_raddr    = r_addr;
      case (r_state)
        R_IDLE: begin
          S_AXI4_ARREADY = 1'b1;
          if (S_AXI4_ARVALID) r_next = R_BIU;
        end
        R_BIU: begin
          biu_renable = 1'b1;
          if (biu_raccept) r_next = R_DATA;
        end
        R_DATA: begin
          S_AXI4_RVALID = 1'b1;
          S_AXI4_RLAST  = (r_cnt == r_len);
          if (S_AXI4_RREADY) r_next = (r_cnt == r_len) ? R_IDLE : R_BIU;
        end
        default: r_next = R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vxe_axi4slv_burst_biu.sv
// Bench for vxe_axi4slv_burst_biu: directed bursts, a burst-level expectation
// model with queues, and one negedge compare process.
module tb_vxe_axi4slv_burst_biu;

  localparam int MAXS = 2;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic        clk = 1'b0;
  logic        S_AXI4_ARESET;
  logic [7:0]  S_AXI4_AWID, S_AXI4_ARID;
  logic [31:0] S_AXI4_AWADDR, S_AXI4_ARADDR;
  logic [7:0]  S_AXI4_AWLEN, S_AXI4_ARLEN;
  logic [2:0]  S_AXI4_AWSIZE, S_AXI4_ARSIZE, S_AXI4_AWPROT, S_AXI4_ARPROT;
  logic [1:0]  S_AXI4_AWBURST, S_AXI4_ARBURST;
  logic        S_AXI4_AWLOCK, S_AXI4_ARLOCK, S_AXI4_AWVALID, S_AXI4_ARVALID;
  logic        S_AXI4_AWREADY, S_AXI4_ARREADY;
  logic [31:0] S_AXI4_WDATA;
  logic [3:0]  S_AXI4_WSTRB;
  logic        S_AXI4_WLAST, S_AXI4_WVALID, S_AXI4_WREADY;
  logic [7:0]  S_AXI4_BID, S_AXI4_RID;
  logic [1:0]  S_AXI4_BRESP, S_AXI4_RRESP;
  logic        S_AXI4_BVALID, S_AXI4_BREADY;
  logic [31:0] S_AXI4_RDATA;
  logic        S_AXI4_RLAST, S_AXI4_RVALID, S_AXI4_RREADY;
  logic [31:0] biu_waddr, biu_wdata, biu_raddr, biu_rdata;
  logic [3:0]  biu_wben;
  logic        biu_wenable, biu_waccept, biu_werror;
  logic        biu_renable, biu_raccept, biu_rerror;

  // BIU responder knobs
  logic        werr_en, rerr_en, rd_ovr_en;
  logic [31:0] werr_addr, rerr_addr, rd_ovr_addr, rd_ovr_data;

  assign biu_werror = werr_en && (biu_waddr == werr_addr);
  assign biu_rerror = rerr_en && (biu_raddr == rerr_addr);
  assign biu_rdata  = (rd_ovr_en && biu_raddr == rd_ovr_addr) ? rd_ovr_data
                    : {biu_raddr[15:0] ^ 16'h5A5A, biu_raddr[15:0]};

  vxe_axi4slv_burst_biu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8)) dut (
    .S_AXI4_ACLK(clk), .S_AXI4_ARESET(S_AXI4_ARESET),
    .S_AXI4_AWID(S_AXI4_AWID), .S_AXI4_AWADDR(S_AXI4_AWADDR), .S_AXI4_AWLEN(S_AXI4_AWLEN),
    .S_AXI4_AWSIZE(S_AXI4_AWSIZE), .S_AXI4_AWBURST(S_AXI4_AWBURST), .S_AXI4_AWLOCK(S_AXI4_AWLOCK),
    .S_AXI4_AWPROT(S_AXI4_AWPROT), .S_AXI4_AWVALID(S_AXI4_AWVALID), .S_AXI4_AWREADY(S_AXI4_AWREADY),
    .S_AXI4_WDATA(S_AXI4_WDATA), .S_AXI4_WSTRB(S_AXI4_WSTRB), .S_AXI4_WLAST(S_AXI4_WLAST),
    .S_AXI4_WVALID(S_AXI4_WVALID), .S_AXI4_WREADY(S_AXI4_WREADY),
    .S_AXI4_BID(S_AXI4_BID), .S_AXI4_BRESP(S_AXI4_BRESP), .S_AXI4_BVALID(S_AXI4_BVALID),
    .S_AXI4_BREADY(S_AXI4_BREADY),
    .S_AXI4_ARID(S_AXI4_ARID), .S_AXI4_ARADDR(S_AXI4_ARADDR), .S_AXI4_ARLEN(S_AXI4_ARLEN),
    .S_AXI4_ARSIZE(S_AXI4_ARSIZE), .S_AXI4_ARBURST(S_AXI4_ARBURST), .S_AXI4_ARLOCK(S_AXI4_ARLOCK),
    .S_AXI4_ARPROT(S_AXI4_ARPROT), .S_AXI4_ARVALID(S_AXI4_ARVALID), .S_AXI4_ARREADY(S_AXI4_ARREADY),
    .S_AXI4_RID(S_AXI4_RID), .S_AXI4_RDATA(S_AXI4_RDATA), .S_AXI4_RRESP(S_AXI4_RRESP),
    .S_AXI4_RLAST(S_AXI4_RLAST), .S_AXI4_RVALID(S_AXI4_RVALID), .S_AXI4_RREADY(S_AXI4_RREADY),
    .biu_waddr(biu_waddr), .biu_wenable(biu_wenable), .biu_wdata(biu_wdata), .biu_wben(biu_wben),
    .biu_waccept(biu_waccept), .biu_werror(biu_werror),
    .biu_raddr(biu_raddr), .biu_renable(biu_renable), .biu_rdata(biu_rdata),
    .biu_raccept(biu_raccept), .biu_rerror(biu_rerror)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wexp_t;
  typedef struct { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [7:0] id; logic [1:0] resp; } bexp_t;

  wexp_t       q_w[$];
  logic [31:0] q_ra[$];
  rexp_t       q_r[$];
  bexp_t       q_b[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Beat k address computed directly from the burst start, not stepwise.
  function automatic logic [31:0] m_addr(input logic [31:0] start, input int len, input int size,
                                         input logic [1:0] burst, input int k);
    int unsigned nb, win, al, base;
    nb = 32'd1 << ((size > MAXS) ? MAXS : size);
    al = start - (start % nb);
    if (k == 0 || burst == FIXED) return start;
    if (burst == WRAP && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      win  = 32'(len + 1) * nb;
      base = start - (start % win);
      return base + ((al - base + 32'(k) * nb) % win);
    end
    return al + 32'(k) * nb;
  endfunction

  function automatic logic [31:0] rd_pattern(input logic [31:0] a);
    if (rd_ovr_en && a == rd_ovr_addr) return rd_ovr_data;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic sig_of(input int which);
    case (which)
      0: return S_AXI4_AWREADY;
      1: return S_AXI4_WREADY;
      2: return S_AXI4_ARREADY;
      3: return S_AXI4_RVALID;
      4: return biu_wenable;
      default: return S_AXI4_BVALID;
    endcase
  endfunction

  // Returns at posedge+1 after the edge where the watched signal was high.
  task automatic wait_ready(input int which, input string name);
    int t = 0;
    @(negedge clk);
    while (!sig_of(which) && t < 200) begin @(negedge clk); t++; end
    chk(name, 64'(sig_of(which)), 64'd1);
    @(posedge clk); #1;
  endtask

  function automatic int qsize(input int which);
    case (which)
      0: return q_w.size();
      1: return q_ra.size();
      2: return q_r.size();
      default: return q_b.size();
    endcase
  endfunction

  task automatic wait_empty(input int which, input string name);
    int t = 0;
    @(negedge clk);
    while (qsize(which) != 0 && t < 300) begin @(negedge clk); t++; end
    chk(name, 64'(qsize(which)), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic hs_aw(input logic [7:0] id, input logic [31:0] a, input int len,
                       input int size, input logic [1:0] burst);
    S_AXI4_AWID = id; S_AXI4_AWADDR = a; S_AXI4_AWLEN = 8'(len); S_AXI4_AWSIZE = 3'(size);
    S_AXI4_AWBURST = burst; S_AXI4_AWVALID = 1'b1;
    wait_ready(0, "aw_handshake");
    S_AXI4_AWVALID = 1'b0;
  endtask

  task automatic hs_ar(input logic [7:0] id, input logic [31:0] a, input int len,
                       input int size, input logic [1:0] burst);
    S_AXI4_ARID = id; S_AXI4_ARADDR = a; S_AXI4_ARLEN = 8'(len); S_AXI4_ARSIZE = 3'(size);
    S_AXI4_ARBURST = burst; S_AXI4_ARVALID = 1'b1;
    wait_ready(2, "ar_handshake");
    S_AXI4_ARVALID = 1'b0;
  endtask

  task automatic hs_w(input logic [31:0] d, input logic [3:0] s, input logic last);
    S_AXI4_WDATA = d; S_AXI4_WSTRB = s; S_AXI4_WLAST = last; S_AXI4_WVALID = 1'b1;
    wait_ready(1, "w_handshake");
    S_AXI4_WVALID = 1'b0; S_AXI4_WLAST = 1'b0;
  endtask

  function automatic logic [31:0] wdat(input logic [31:0] base, input int k);
    return base ^ (32'(k) * 32'h01010101);
  endfunction

  function automatic logic [3:0] wstb(input int k);
    return 4'hF >> (k % 4);
  endfunction

  task automatic do_write(input logic [7:0] id, input logic [31:0] a, input int len, input int size,
                          input logic [1:0] burst, input logic [31:0] dbase, input int wlast_beat);
    logic        err = 1'b0;
    logic [31:0] ba;
    for (int k = 0; k <= len; k++) begin
      ba = m_addr(a, len, size, burst, k);
      q_w.push_back('{ba, wdat(dbase, k), wstb(k)});
      if (werr_en && ba == werr_addr) err = 1'b1;
      if ((k == wlast_beat) != (k == len)) err = 1'b1;
    end
    q_b.push_back('{id, err ? 2'b10 : 2'b00});
    hs_aw(id, a, len, size, burst);
    for (int k = 0; k <= len; k++) hs_w(wdat(dbase, k), wstb(k), k == wlast_beat);
    wait_empty(3, "write_b_done");
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] a, input int len, input int size,
                         input logic [1:0] burst);
    logic [31:0] ba;
    for (int k = 0; k <= len; k++) begin
      ba = m_addr(a, len, size, burst, k);
      q_ra.push_back(ba);
      q_r.push_back('{id, rd_pattern(ba), (rerr_en && ba == rerr_addr) ? 2'b10 : 2'b00, k == len});
    end
    hs_ar(id, a, len, size, burst);
    wait_empty(2, "read_r_done");
  endtask

  // Compare process: previous-cycle observations for latency and stability rules.
  logic        p_aw_hs, p_w_hs, p_wacc, p_ar_hs, p_racc, p_wstall, p_rstall, p_bstall;
  logic [31:0] p_waddr, p_wdata, p_rdata;
  logic [3:0]  p_wben;
  logic [7:0]  p_rid, p_bid;
  logic [1:0]  p_rresp, p_bresp;
  logic        p_rlast;

  initial begin : compare
    wexp_t we; rexp_t re; bexp_t be; logic [31:0] ra;
    {p_aw_hs, p_w_hs, p_wacc, p_ar_hs, p_racc, p_wstall, p_rstall, p_bstall} = '0;
    forever begin
      @(negedge clk);
      if (S_AXI4_ARESET) begin
        chk("reset_outputs_zero", 64'(|{S_AXI4_AWREADY, S_AXI4_WREADY, S_AXI4_BVALID, S_AXI4_ARREADY,
            S_AXI4_RVALID, S_AXI4_RLAST, biu_wenable, biu_renable, S_AXI4_BID, S_AXI4_BRESP,
            S_AXI4_RID, S_AXI4_RDATA, S_AXI4_RRESP, biu_waddr, biu_wdata, biu_wben, biu_raddr}), 64'd0);
        {p_aw_hs, p_w_hs, p_wacc, p_ar_hs, p_racc, p_wstall, p_rstall, p_bstall} = '0;
      end else begin
        if (p_aw_hs) chk("aw_to_wready", 64'(S_AXI4_WREADY), 64'd1);
        if (p_w_hs)  chk("w_to_wenable", 64'(biu_wenable), 64'd1);
        if (p_wacc)  chk("waccept_to_next", 64'(S_AXI4_BVALID | S_AXI4_WREADY), 64'd1);
        if (p_ar_hs) chk("ar_to_renable", 64'(biu_renable), 64'd1);
        if (p_racc)  chk("raccept_to_rvalid", 64'(S_AXI4_RVALID), 64'd1);
        if (p_wstall)
          chk("biu_w_stable", {biu_wenable, biu_wben, biu_waddr[26:0], biu_wdata},
              {1'b1, p_wben, p_waddr[26:0], p_wdata});
        if (p_rstall) begin
          chk("r_stable", {S_AXI4_RVALID, S_AXI4_RLAST, S_AXI4_RRESP, S_AXI4_RID, S_AXI4_RDATA},
              {1'b1, p_rlast, p_rresp, p_rid, p_rdata});
          chk("no_renable_in_r_stall", 64'(biu_renable), 64'd0);
        end
        if (p_bstall) chk("b_held", {S_AXI4_BVALID, S_AXI4_BID, S_AXI4_BRESP}, {1'b1, p_bid, p_bresp});

        if (biu_wenable && biu_waccept) begin
          if (q_w.size() == 0) chk("biu_w_unexpected", 64'd1, 64'd0);
          else begin
            we = q_w.pop_front();
            chk("biu_waddr", 64'(biu_waddr), 64'(we.addr));
            chk("biu_wdata", 64'(biu_wdata), 64'(we.data));
            chk("biu_wben", 64'(biu_wben), 64'(we.strb));
          end
        end
        if (biu_renable && biu_raccept) begin
          if (q_ra.size() == 0) chk("biu_r_unexpected", 64'd1, 64'd0);
          else begin
            ra = q_ra.pop_front();
            chk("biu_raddr", 64'(biu_raddr), 64'(ra));
          end
        end
        if (S_AXI4_RVALID && S_AXI4_RREADY) begin
          if (q_r.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
          else begin
            re = q_r.pop_front();
            chk("r_beat", {S_AXI4_RID, S_AXI4_RRESP, S_AXI4_RLAST, S_AXI4_RDATA},
                {re.id, re.resp, re.last, re.data});
          end
        end
        if (S_AXI4_BVALID && S_AXI4_BREADY) begin
          if (q_b.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
          else begin
            be = q_b.pop_front();
            chk("b_resp", {S_AXI4_BID, S_AXI4_BRESP}, {be.id, be.resp});
          end
        end

        p_aw_hs  = S_AXI4_AWVALID && S_AXI4_AWREADY;
        p_w_hs   = S_AXI4_WVALID && S_AXI4_WREADY;
        p_wacc   = biu_wenable && biu_waccept;
        p_ar_hs  = S_AXI4_ARVALID && S_AXI4_ARREADY;
        p_racc   = biu_renable && biu_raccept;
        p_wstall = biu_wenable && !biu_waccept;
        p_rstall = S_AXI4_RVALID && !S_AXI4_RREADY;
        p_bstall = S_AXI4_BVALID && !S_AXI4_BREADY;
        p_waddr = biu_waddr; p_wdata = biu_wdata; p_wben = biu_wben;
        p_rdata = S_AXI4_RDATA; p_rid = S_AXI4_RID; p_rresp = S_AXI4_RRESP; p_rlast = S_AXI4_RLAST;
        p_bid = S_AXI4_BID; p_bresp = S_AXI4_BRESP;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    S_AXI4_ARESET = 1'b1;
    S_AXI4_AWID = '0; S_AXI4_AWADDR = '0; S_AXI4_AWLEN = '0; S_AXI4_AWSIZE = '0; S_AXI4_AWBURST = '0;
    S_AXI4_AWLOCK = 1'b1; S_AXI4_AWPROT = 3'b010; S_AXI4_AWVALID = 1'b0;
    S_AXI4_ARID = '0; S_AXI4_ARADDR = '0; S_AXI4_ARLEN = '0; S_AXI4_ARSIZE = '0; S_AXI4_ARBURST = '0;
    S_AXI4_ARLOCK = 1'b1; S_AXI4_ARPROT = 3'b101; S_AXI4_ARVALID = 1'b0;
    S_AXI4_WDATA = '0; S_AXI4_WSTRB = '0; S_AXI4_WLAST = 1'b0; S_AXI4_WVALID = 1'b0;
    S_AXI4_BREADY = 1'b1; S_AXI4_RREADY = 1'b1;
    biu_waccept = 1'b1; biu_raccept = 1'b1;
    werr_en = 1'b0; rerr_en = 1'b0; rd_ovr_en = 1'b0;
    werr_addr = '0; rerr_addr = '0; rd_ovr_addr = '0; rd_ovr_data = '0;

    // Model pinned against hand-computed addresses
    chk("model_wrap_b1", 64'(m_addr(32'h38, 3, 2, WRAP, 1)), 64'h3C);
    chk("model_wrap_b2", 64'(m_addr(32'h38, 3, 2, WRAP, 2)), 64'h30);
    chk("model_wrap_b3", 64'(m_addr(32'h38, 3, 2, WRAP, 3)), 64'h34);
    chk("model_incr_b3", 64'(m_addr(32'h10, 3, 2, INCR, 3)), 64'h1C);
    chk("model_fixed_b2", 64'(m_addr(32'h40, 2, 2, FIXED, 2)), 64'h40);
    chk("model_unaligned_b1", 64'(m_addr(32'h12, 1, 2, INCR, 1)), 64'h14);

    repeat (3) @(posedge clk);
    #1 S_AXI4_ARESET = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {S_AXI4_AWREADY, S_AXI4_ARREADY, S_AXI4_WREADY, S_AXI4_BVALID,
        S_AXI4_RVALID, biu_wenable, biu_renable}, 7'b1100000);
    @(posedge clk); #1;

    // Single read with literal expectations
    rd_ovr_en = 1'b1; rd_ovr_addr = 32'h0C; rd_ovr_data = 32'hFEFEFAFA;
    q_ra.push_back(32'h0C);
    q_r.push_back('{8'h01, 32'hFEFEFAFA, 2'b00, 1'b1});
    hs_ar(8'h01, 32'h0C, 0, 2, INCR);
    wait_empty(2, "single_read_done");
    rd_ovr_en = 1'b0;

    do_write(8'h02, 32'h10, 3, 2, INCR, 32'hD0D0D0D0, 3);
    do_read(8'h03, 32'h38, 3, 2, WRAP);
    do_read(8'h04, 32'h40, 2, 2, FIXED);

    // Backpressure: RREADY, waccept, BREADY each low for 3 cycles
    S_AXI4_RREADY = 1'b0;
    fork
      do_read(8'h05, 32'h80, 1, 2, INCR);
      begin wait_ready(3, "rvalid_seen"); repeat (2) @(posedge clk); #1 S_AXI4_RREADY = 1'b1; end
    join
    biu_waccept = 1'b0;
    fork
      do_write(8'h06, 32'h90, 1, 2, INCR, 32'h90909090, 1);
      begin wait_ready(4, "wenable_seen"); repeat (2) @(posedge clk); #1 biu_waccept = 1'b1; end
    join
    S_AXI4_BREADY = 1'b0;
    fork
      do_write(8'h0F, 32'hB0, 0, 2, INCR, 32'hB0B0B0B0, 0);
      begin wait_ready(5, "bvalid_seen"); repeat (2) @(posedge clk); #1 S_AXI4_BREADY = 1'b1; end
    join

    // Error handling
    werr_en = 1'b1; werr_addr = 32'hA4;
    do_write(8'h0B, 32'hA0, 3, 2, INCR, 32'hA0A0A0A0, 3);
    werr_en = 1'b0;
    rerr_en = 1'b1; rerr_addr = 32'hC8;
    do_read(8'h0C, 32'hC0, 3, 2, INCR);
    rerr_en = 1'b0;
    do_write(8'h0D, 32'hE0, 3, 2, INCR, 32'hE0E0E0E0, 1);

    // Concurrent, unaligned and byte-sized bursts
    fork
      do_write(8'h09, 32'h12, 1, 2, INCR, 32'h12121212, 1);
      do_read(8'h0A, 32'h101, 2, 0, INCR);
    join

    // Reset while write sits on beat 2 and read on beat 1
    biu_raccept = 1'b0;
    hs_ar(8'h07, 32'h300, 3, 2, INCR);
    q_w.push_back('{32'h200, 32'hC0DE0000, 4'hF});
    hs_aw(8'h06, 32'h200, 3, 2, INCR);
    hs_w(32'hC0DE0000, 4'hF, 1'b0);
    wait_empty(0, "mid_burst_beat0");
    biu_waccept = 1'b0;
    hs_w(32'hC0DE0001, 4'hF, 1'b0);
    @(posedge clk); #1;
    S_AXI4_ARESET = 1'b1;
    q_w.delete(); q_ra.delete(); q_r.delete(); q_b.delete();
    repeat (2) @(posedge clk);
    #1 S_AXI4_ARESET = 1'b0;
    biu_waccept = 1'b1; biu_raccept = 1'b1;
    @(negedge clk);
    chk("release_ready", {S_AXI4_AWREADY, S_AXI4_ARREADY, S_AXI4_BVALID, S_AXI4_RVALID}, 4'b1100);
    @(posedge clk); #1;

    q_w.push_back('{32'h0C, 32'hF1F2F3F4, 4'hF});
    q_b.push_back('{8'h05, 2'b00});
    hs_aw(8'h05, 32'h0C, 0, 2, INCR);
    hs_w(32'hF1F2F3F4, 4'hF, 1'b1);
    wait_empty(3, "post_reset_write_done");

    repeat (5) @(posedge clk);
    #1;
    chk("leftover_w", 64'(q_w.size()), 64'd0);
    chk("leftover_r", 64'(q_r.size() + q_ra.size()), 64'd0);
    chk("leftover_b", 64'(q_b.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
